// File: rtl/cbs_layer_sched_if.sv
// Handshake bundle of cbs_layer_sched: frame control, frame-RAM window requests,
// per-channel conv results in, and the valid/ready lane-sum stream out.
interface cbs_layer_sched_if #(
    parameter int LANES  = 8,
    parameter int IN_CH  = 3,
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 26
);
    logic                         start;
    logic [ADDR_W-1:0]            base_addr;
    logic                         busy;
    logic                         done;
    logic                         rd_en;
    logic [ADDR_W-1:0]            rd_addr;
    logic                         conv_valid;
    logic [IN_CH*LANES*ACC_W-1:0] conv_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES*ACC_W-1:0]       out_data;
    logic [LANES-1:0]             out_mask;
    logic                         out_last;

    modport master (
        output start, base_addr, conv_valid, conv_in, out_ready,
        input  busy, done, rd_en, rd_addr, out_valid, out_data, out_mask, out_last
    );

    modport slave (
        input  start, base_addr, conv_valid, conv_in, out_ready,
        output busy, done, rd_en, rd_addr, out_valid, out_data, out_mask, out_last
    );
endinterface

// File: rtl/cbs_layer_sched.sv
// Frame tile scheduler + lane-wise channel summer; 1-cycle conv-to-FIFO latency, issue gated by credits
// (outstanding + in-flight + FIFO occupancy < FIFO_DEPTH). Define CBS_SAT_EN to saturate lane sums instead of wrapping.
module cbs_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [W-1:0]           push_dat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           pop_dat_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] cnt_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_pop;

    assign do_pop    = pop_i && (cnt_q != '0);
    assign pop_dat_o = mem_q[rd_q];
    assign empty_o   = (cnt_q == '0);
    assign cnt_o     = cnt_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= push_dat_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
        end
    end
endmodule

module cbs_layer_sched #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 640,
    parameter int LANES      = 8,
    parameter int IN_CH      = 3,
    parameter int ACC_W      = 16,
    parameter int ADDR_W     = 26,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    cbs_layer_sched_if.slave  bus
);
    localparam int OR_N   = IMG_H - 2;
    localparam int OC_N   = IMG_W - 2;
    localparam int T_N    = (OC_N + LANES - 1) / LANES;
    localparam int LAST_N = OC_N - (T_N - 1) * LANES;
    localparam int RW     = $clog2(OR_N + 1);
    localparam int TW     = $clog2(T_N + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CW     = CNT_W + 1;
    localparam int OW     = LANES * ACC_W + LANES + 1;
`ifdef CBS_SAT_EN
    localparam int EXT    = $clog2(IN_CH);
    localparam int SW     = ACC_W + EXT;
`else
    localparam int SW     = ACC_W;
`endif

    localparam logic [RW-1:0]     R_LAST    = RW'(OR_N - 1);
    localparam logic [TW-1:0]     T_LAST    = TW'(T_N - 1);
    localparam logic [ADDR_W-1:0] TILE_INC  = ADDR_W'(LANES);
    localparam logic [ADDR_W-1:0] WRAP_INC  = ADDR_W'(IMG_W - (T_N - 1) * LANES);
    localparam logic [LANES-1:0]  FULL_MASK = {LANES{1'b1}};
    localparam logic [LANES-1:0]  TAIL_MASK = FULL_MASK >> (LANES - LAST_N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [RW-1:0]          row_q, row_d;
    logic [TW-1:0]          tile_q, tile_d;
    logic                   pipe_vld_q;
    logic [LANES*ACC_W-1:0] pipe_dat_q;
    logic [LANES:0]         pipe_tag_q;

    logic                   issue, is_last, acc, credit_ok;
    logic [LANES:0]         tag_head;
    logic                   tag_empty, ofifo_empty;
    logic [CNT_W-1:0]       tag_cnt, ofifo_cnt;
    logic [OW-1:0]          ofifo_head;
    logic [LANES*ACC_W-1:0] sum_dat;
    logic signed [ACC_W-1:0] ch;
    logic signed [SW-1:0]    lane_s;

    // The tag FIFO holds one entry per outstanding request, so its count is the outstanding count.
    assign credit_ok = (CW'(tag_cnt) + CW'(pipe_vld_q) + CW'(ofifo_cnt)) < CW'(FIFO_DEPTH);
    assign issue     = (state_q == S_ISSUE) && credit_ok;
    assign is_last   = (row_q == R_LAST) && (tile_q == T_LAST);
    assign acc       = bus.conv_valid && !tag_empty;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        row_d   = row_q;
        tile_d  = tile_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = S_ISSUE;
                addr_d  = bus.base_addr;
                row_d   = '0;
                tile_d  = '0;
            end
            S_ISSUE: if (issue) begin
                if (is_last) begin
                    state_d = S_DRAIN;
                end else if (tile_q == T_LAST) begin
                    tile_d = '0;
                    row_d  = row_q + 1'b1;
                    addr_d = addr_q + WRAP_INC;
                end else begin
                    tile_d = tile_q + 1'b1;
                    addr_d = addr_q + TILE_INC;
                end
            end
            S_DRAIN: if (tag_empty && !pipe_vld_q && ofifo_empty) state_d = S_FIN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sum_dat = '0;
        ch      = '0;
        lane_s  = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_s = '0;
            for (int c = 0; c < IN_CH; c++) begin
                ch     = bus.conv_in[(c*LANES+l)*ACC_W +: ACC_W];
                lane_s = lane_s + SW'(ch);
            end
`ifdef CBS_SAT_EN
            if (lane_s[SW-1:ACC_W-1] != {(EXT+1){lane_s[SW-1]}})
                sum_dat[l*ACC_W +: ACC_W] = lane_s[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                         : {1'b0, {(ACC_W-1){1'b1}}};
            else
                sum_dat[l*ACC_W +: ACC_W] = lane_s[ACC_W-1:0];
`else
            sum_dat[l*ACC_W +: ACC_W] = lane_s;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            row_q      <= '0;
            tile_q     <= '0;
            pipe_vld_q <= 1'b0;
            pipe_dat_q <= '0;
            pipe_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            row_q      <= row_d;
            tile_q     <= tile_d;
            pipe_vld_q <= acc;
            if (acc) begin
                pipe_dat_q <= sum_dat;
                pipe_tag_q <= tag_head;
            end
        end
    end

    cbs_fifo #(.W(LANES + 1), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (issue),
        .push_dat_i({is_last, (tile_q == T_LAST) ? TAIL_MASK : FULL_MASK}),
        .pop_i     (acc),
        .pop_dat_o (tag_head),
        .empty_o   (tag_empty),
        .cnt_o     (tag_cnt)
    );

    cbs_fifo #(.W(OW), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (pipe_vld_q),
        .push_dat_i({pipe_tag_q, pipe_dat_q}),
        .pop_i     (bus.out_ready),
        .pop_dat_o (ofifo_head),
        .empty_o   (ofifo_empty),
        .cnt_o     (ofifo_cnt)
    );

    assign bus.busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign bus.done      = (state_q == S_FIN);
    assign bus.rd_en     = issue;
    assign bus.rd_addr   = addr_q;
    assign bus.out_valid = !ofifo_empty;
    assign {bus.out_last, bus.out_mask, bus.out_data} = ofifo_empty ? '0 : ofifo_head;
endmodule
